// File: rtl/risc_v_pkg.sv
// Shared RISC-V definitions: major opcodes, instruction format select and the canonical NOP.
// Consumed by instr_encoder and its optional range checker.
package risc_v;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_enc_range_chk.sv
// Combinational legality check of the immediate against the selected format.
// Only instantiated when INSTR_ENC_RANGE_CHECK_EN is defined.
module instr_enc_range_chk
    import risc_v::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [31:0] imm_i,
    output logic        err_o
);

    logic signed [31:0] simm;
    assign simm = $signed(imm_i);

    always_comb begin
        err_o = 1'b0;
        case (fmt_i)
            FMT_R:        err_o = 1'b0;
            FMT_I, FMT_S: err_o = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        err_o = (simm < -32'sd4096) || (simm > 32'sd4094) || imm_i[0];
            FMT_U:        err_o = (imm_i[11:0] != 12'd0);
            FMT_J:        err_o = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm_i[0];
            default:      err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs RISC-V instruction fields into a 32-bit word behind a one-deep valid/ready output stage.
// Define INSTR_ENC_RANGE_CHECK_EN to flag out-of-range immediates and illegal formats on err_o.
module instr_encoder
    import risc_v::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        err_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // The input side takes a bundle when the output slot is empty or being drained this cycle;
    // reset and flush both block acceptance.
    logic accept;
    logic out_hs;
    logic [31:0] word;
    logic err_next;

    assign in_ready_o = !rst_i && !flush_i && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_o && out_ready_i;

    always_comb begin
        word = NOP;
        case (fmt_i)
            FMT_R: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: word = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: word = NOP;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    instr_enc_range_chk u_range_chk (
        .fmt_i (fmt_i),
        .imm_i (imm_i),
        .err_o (err_next)
    );
`else
    assign err_next = 1'b0;
`endif

    // addr_o is the address counter itself; it advances as each word leaves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            instr_o     <= 32'h0;
            addr_o      <= BASE_ADDR;
            err_o       <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            instr_o     <= 32'h0;
            addr_o      <= BASE_ADDR;
            err_o       <= 1'b0;
        end else begin
            if (out_hs) begin
                addr_o <= addr_o + 32'd4;
            end
            if (accept) begin
                out_valid_o <= 1'b1;
                instr_o     <= word;
                err_o       <= err_next;
            end else if (out_hs) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table with scoreboard plus directed
// sequences for back-pressure, address wrap, flush and mid-transfer reset.
module tb_instr_encoder;
    import risc_v::*;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] WBASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, err;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, instr, addr;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
    logic [31:0] w_instr, w_addr;

    int checks = 0;
    int passes = 0;
    bit rand_ready = 1'b0;

    logic [64:0] exp_q[$];
    logic [31:0] next_addr;
    logic [31:0] cur_instr;
    logic        cur_err;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .instr_o(instr), .addr_o(addr), .err_o(err)
    );

    // Second instance shares the field inputs but has its own handshake to exercise wrap.
    instr_encoder #(.BASE_ADDR(WBASE)) dut_w (
        .clk_i(clk), .rst_i(rst), .flush_i(w_flush),
        .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
        .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
        .out_valid_o(w_out_valid), .out_ready_i(w_out_ready),
        .instr_o(w_instr), .addr_o(w_addr), .err_o(w_err)
    );

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                                input logic [31:0] ins, input logic ill);
        vec_t v;
        v.fmt = f; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.f3 = f3; v.f7 = f7; v.imm = im; v.instr = ins; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
        cur_instr = v.instr;
        cur_err   = RC ? v.ill : 1'b0;
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        bit acc = 1'b0;
        apply(v);
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bit done = 1'b0;
        out_ready = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            done = !out_valid && (exp_q.size() == 0);
            n++;
        end
        if (!done) begin
            checks++;
            $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard: compare outgoing words first, then record the bundle accepted on the next edge.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                exp_q.delete();
                next_addr = BASE;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL spurious_word: got %h, expected no word", instr);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_instr", instr, e[31:0]);
                        check("sb_addr", addr, e[63:32]);
                        check("sb_err", {31'd0, err}, {31'd0, e[64]});
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({cur_err, next_addr, cur_instr});
                    next_addr = next_addr + 32'd4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        vecs[0]  = mk(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 1'b0);
        vecs[1]  = mk(FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4,       32'hFE20_8EE3, 1'b0);
        vecs[2]  = mk(FMT_J, OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0);
        vecs[3]  = mk(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h8000_0093, 1'b1);
        vecs[4]  = mk(FMT_R, OPC_OP,     5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0,        32'h4052_01B3, 1'b0);
        vecs[5]  = mk(FMT_S, OPC_STORE,  5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'd8,         32'h0011_2423, 1'b0);
        vecs[6]  = mk(FMT_U, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        vecs[7]  = mk(FMT_U, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678, 32'h1234_52B7, 1'b1);
        vecs[8]  = mk(3'd6,  OPC_OP,     5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1);
        vecs[9]  = mk(FMT_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         32'h0000_0163, 1'b1);
        vecs[10] = mk(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048,    32'h8000_0093, 1'b0);
        vecs[11] = mk(FMT_J, OPC_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2,       32'hFFFF_F06F, 1'b0);
        vecs[12] = mk(FMT_I, OPC_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd7, 7'd0, -32'sd1,       32'hFFF1_F113, 1'b0);
        vecs[13] = mk(FMT_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      32'h8000_0063, 1'b1);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
        next_addr = BASE;
        apply(vecs[0]);

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", addr, BASE);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Address wrap on the second instance
        apply(vecs[0]);
        w_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) w_in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("wrap_valid_%0d", k), {31'd0, w_out_valid}, 32'd1);
            check($sformatf("wrap_addr_%0d", k), w_addr, WBASE + 32'(4 * k));
            check($sformatf("wrap_instr_%0d", k), w_instr, 32'h0050_0093);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("wrap_idle", {31'd0, w_out_valid}, 32'd0);
        @(posedge clk); #1;

        // Back-pressure: three back-to-back words, sink stalled for three cycles after the first
        out_ready = 1'b0;
        apply(vecs[0]); in_valid = 1'b1;
        @(posedge clk); #1;
        apply(vecs[1]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("hold_instr_%0d", k), instr, 32'h0050_0093);
            check($sformatf("hold_addr_%0d", k), addr, BASE);
            check($sformatf("hold_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("seq_addr_0", addr, BASE);
        @(posedge clk); #1;
        apply(vecs[2]);
        @(negedge clk);
        check("seq_valid_1", {31'd0, out_valid}, 32'd1);
        check("seq_addr_1", addr, BASE + 32'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("seq_valid_2", {31'd0, out_valid}, 32'd1);
        check("seq_addr_2", addr, BASE + 32'd8);
        @(posedge clk); #1;
        drain();

        // Vector table under random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 14; i++) send(vecs[i]);
        for (int r = 0; r < 20; r++) send(vecs[$urandom_range(0, 13)]);
        rand_ready = 1'b0;
        @(posedge clk); #1;
        drain();

        // Flush with a held word; a pending bundle must not be taken
        out_ready = 1'b0;
        send(vecs[4]);
        @(negedge clk);
        check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        apply(vecs[5]); in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_addr", addr, BASE);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        send(vecs[6]);
        drain();

        // Reset asserted mid-transfer
        out_ready = 1'b0;
        send(vecs[12]);
        #3;
        rst = 1'b1;
        apply(vecs[5]); in_valid = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_addr", addr, BASE);
        check("midrst_instr", instr, 32'h0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk); #2;
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[5]);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
